// File: rtl/capture_seq.sv
// Capture sequencer: arms/aborts the capture block, enforces a trigger timeout,
// counts FIFO readout beats and reports completion, errors and trigger position.
module capture_seq #(
  parameter int saddr_w   = 24,
  parameter int timeout_w = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 continuous,
  input  logic [timeout_w-1:0] timeout,
  input  logic [saddr_w-1:0]   buffer_size,
  output logic                 cap_arm,
  output logic                 cap_abort,
  input  logic                 cap_ready,
  input  logic                 cap_armed,
  input  logic                 cap_triggered,
  input  logic                 cap_done,
  input  logic [saddr_w-1:0]   cap_trigger_pos,
  input  logic                 dma_valid,
  input  logic                 dma_ready,
  input  logic                 dma_last,
  output logic                 busy,
  output logic                 irq,
  output logic [saddr_w-1:0]   trig_pos,
  output logic [15:0]          cap_count,
  output logic                 err_timeout,
  output logic                 err_frame,
  output logic                 aborted,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ARM        = 3'd1,
    S_WAIT_ARMED = 3'd2,
    S_WAIT_TRIG  = 3'd3,
    S_WAIT_DONE  = 3'd4,
    S_DRAIN      = 3'd5,
    S_ABORT      = 3'd6,
    S_FINISH     = 3'd7
  } state_t;

  localparam logic [timeout_w-1:0] tmo_one  = timeout_w'(1);
  localparam logic [saddr_w-1:0]   beat_one = saddr_w'(1);

  state_t               cur;
  logic                 stop_pend;
  logic [timeout_w-1:0] tmo_cnt;
  logic [saddr_w-1:0]   beat_cnt;
  logic                 tmo_hit;
  logic                 beat;
  logic                 last_beat;

  // Abort on the edge where the count of waiting cycles reaches the limit.
  assign tmo_hit   = (timeout != '0) && (tmo_cnt >= timeout - tmo_one);
  assign beat      = dma_valid && dma_ready;
  assign last_beat = (beat_cnt == buffer_size - beat_one);
  assign state     = cur;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur         <= S_IDLE;
      cap_arm     <= 1'b0;
      cap_abort   <= 1'b0;
      busy        <= 1'b0;
      irq         <= 1'b0;
      trig_pos    <= '0;
      cap_count   <= '0;
      err_timeout <= 1'b0;
      err_frame   <= 1'b0;
      aborted     <= 1'b0;
      stop_pend   <= 1'b0;
      tmo_cnt     <= '0;
      beat_cnt    <= '0;
    end else begin
      cap_arm <= 1'b0;
      irq     <= 1'b0;
      case (cur)
        S_IDLE: begin
          if (start && cap_ready) begin
            cur         <= S_ARM;
            cap_arm     <= 1'b1;
            busy        <= 1'b1;
            err_timeout <= 1'b0;
            err_frame   <= 1'b0;
            aborted     <= 1'b0;
            stop_pend   <= 1'b0;
            tmo_cnt     <= '0;
            beat_cnt    <= '0;
          end
        end
        S_ARM: begin
          cur <= S_WAIT_ARMED;
          if (stop) stop_pend <= 1'b1;
        end
        S_WAIT_ARMED, S_WAIT_TRIG: begin
          if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + tmo_one;
          if (stop || stop_pend) begin
            cur       <= S_ABORT;
            cap_abort <= 1'b1;
            aborted   <= 1'b1;
          end else if (tmo_hit) begin
            cur         <= S_ABORT;
            cap_abort   <= 1'b1;
            err_timeout <= 1'b1;
          end else if (cur == S_WAIT_ARMED && cap_armed) begin
            cur <= S_WAIT_TRIG;
          end else if (cur == S_WAIT_TRIG && cap_triggered) begin
            cur      <= S_WAIT_DONE;
            trig_pos <= cap_trigger_pos;
          end
        end
        S_WAIT_DONE: begin
          if (stop) begin
            cur       <= S_ABORT;
            cap_abort <= 1'b1;
            aborted   <= 1'b1;
          end else if (cap_done) begin
            cur <= S_DRAIN;
          end
        end
        // A stop here only takes effect once the readout has completed.
        S_DRAIN: begin
          if (stop) stop_pend <= 1'b1;
          if (beat) begin
            if (last_beat) begin
              cur       <= S_FINISH;
              irq       <= 1'b1;
              cap_count <= cap_count + 16'd1;
              if (!dma_last) err_frame <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + beat_one;
              if (dma_last) err_frame <= 1'b1;
            end
          end
        end
        S_FINISH: begin
          if (continuous && !stop_pend && !stop) begin
            cur      <= S_ARM;
            cap_arm  <= 1'b1;
            tmo_cnt  <= '0;
            beat_cnt <= '0;
          end else begin
            cur  <= S_IDLE;
            busy <= 1'b0;
            if (stop) stop_pend <= 1'b1;
          end
        end
        S_ABORT: begin
          if (cap_ready) begin
            cur       <= S_IDLE;
            cap_abort <= 1'b0;
            busy      <= 1'b0;
            irq       <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_seq.sv
// Self-checking bench for capture_seq: a table of single-cycle vectors, then
// hand-written multi-cycle sequences acting as the capture block and FIFO.
module tb_capture_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, stop, continuous;
  logic [31:0] timeout;
  logic [23:0] buffer_size;
  logic        cap_arm, cap_abort;
  logic        cap_ready, cap_armed, cap_triggered, cap_done;
  logic [23:0] cap_trigger_pos;
  logic        dma_valid, dma_ready, dma_last;
  logic        busy, irq;
  logic [23:0] trig_pos;
  logic [15:0] cap_count;
  logic        err_timeout, err_frame, aborted;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  int irq_seen = 0;
  int exp_count = 0;

  capture_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .continuous(continuous), .timeout(timeout), .buffer_size(buffer_size),
    .cap_arm(cap_arm), .cap_abort(cap_abort), .cap_ready(cap_ready),
    .cap_armed(cap_armed), .cap_triggered(cap_triggered), .cap_done(cap_done),
    .cap_trigger_pos(cap_trigger_pos), .dma_valid(dma_valid),
    .dma_ready(dma_ready), .dma_last(dma_last), .busy(busy), .irq(irq),
    .trig_pos(trig_pos), .cap_count(cap_count), .err_timeout(err_timeout),
    .err_frame(err_frame), .aborted(aborted), .state(state)
  );

  always #5 clk = ~clk;

  // Sampled before the edge updates it, so each pulse is counted once.
  always @(posedge clk) if (irq) irq_seen <= irq_seen + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic       start, stop, ready, armed, trig, done, dv, dl;
    logic [2:0] st;
    logic       busy, arm, abort, irq;
  } vec_t;

  function automatic vec_t mk(input logic a_start, a_stop, a_ready, a_armed,
                              a_trig, a_done, a_dv, a_dl, input logic [2:0] e_st,
                              input logic e_busy, e_arm, e_abort, e_irq);
    vec_t v;
    v.start = a_start; v.stop = a_stop; v.ready = a_ready; v.armed = a_armed;
    v.trig = a_trig; v.done = a_done; v.dv = a_dv; v.dl = a_dl;
    v.st = e_st; v.busy = e_busy; v.arm = e_arm; v.abort = e_abort; v.irq = e_irq;
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start = v.start; stop = v.stop; cap_ready = v.ready; cap_armed = v.armed;
    cap_triggered = v.trig; cap_done = v.done; dma_valid = v.dv; dma_last = v.dl;
    tick();
  endtask

  task automatic do_start();
    cap_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("start.state", state, 1);
    checkOutput("start.cap_arm", cap_arm, 1);
  endtask

  // From ARM: armed, wait, trigger, done -> DRAIN.
  task automatic to_drain(input int trig_delay, input logic [23:0] tpos);
    tick();
    checkOutput("to_drain.wait_armed", state, 2);
    cap_armed = 1'b1;
    tick();
    cap_armed = 1'b0;
    checkOutput("to_drain.wait_trig", state, 3);
    repeat (trig_delay) tick();
    cap_trigger_pos = tpos;
    cap_triggered = 1'b1;
    tick();
    cap_triggered = 1'b0;
    checkOutput("to_drain.wait_done", state, 4);
    cap_done = 1'b1;
    tick();
    cap_done = 1'b0;
    checkOutput("to_drain.drain", state, 5);
  endtask

  // Deliver n beats with stall/idle cycles mixed in; dma_last on beats la/lb.
  task automatic drain(input int n, input int la, input int lb, input int stop_at);
    for (int i = 0; i < n; i++) begin
      if (i == 5) begin
        dma_valid = 1'b1; dma_ready = 1'b0; dma_last = 1'b1;
        tick();
        dma_ready = 1'b1;
      end
      if (i == 9) begin
        dma_valid = 1'b0; dma_last = 1'b1;
        tick();
      end
      dma_valid = 1'b1;
      dma_last  = (i == la) || (i == lb);
      stop      = (i == stop_at);
      tick();
      stop = 1'b0;
    end
    dma_valid = 1'b0;
    dma_last  = 1'b0;
  endtask

  vec_t vecs[15];
  int   base;
  int   n;

  initial begin
    reset_n = 1'b0;
    start = 0; stop = 0; continuous = 0; timeout = 0; buffer_size = 24'd2;
    cap_ready = 0; cap_armed = 0; cap_triggered = 0; cap_done = 0;
    cap_trigger_pos = 24'h00ABCD; dma_valid = 0; dma_ready = 1; dma_last = 0;

    vecs[0]  = mk(1,0,0,0,0,0,0,0, 3'd0, 0,0,0,0);
    vecs[1]  = mk(1,0,1,0,0,0,0,0, 3'd1, 1,1,0,0);
    vecs[2]  = mk(0,0,1,0,0,0,0,0, 3'd2, 1,0,0,0);
    vecs[3]  = mk(0,0,1,1,0,0,0,0, 3'd3, 1,0,0,0);
    vecs[4]  = mk(0,0,1,0,1,0,0,0, 3'd4, 1,0,0,0);
    vecs[5]  = mk(0,0,1,0,0,1,0,0, 3'd5, 1,0,0,0);
    vecs[6]  = mk(0,0,1,0,0,0,1,0, 3'd5, 1,0,0,0);
    vecs[7]  = mk(0,0,1,0,0,0,1,1, 3'd7, 1,0,0,1);
    vecs[8]  = mk(0,0,1,0,0,0,0,0, 3'd0, 0,0,0,0);
    vecs[9]  = mk(1,0,1,0,0,0,0,0, 3'd1, 1,1,0,0);
    vecs[10] = mk(0,1,1,0,0,0,0,0, 3'd2, 1,0,0,0);
    vecs[11] = mk(0,0,0,0,0,0,0,0, 3'd6, 1,0,1,0);
    vecs[12] = mk(0,0,0,0,0,0,0,0, 3'd6, 1,0,1,0);
    vecs[13] = mk(0,0,1,0,0,0,0,0, 3'd0, 0,0,0,1);
    vecs[14] = mk(0,0,1,0,0,0,0,0, 3'd0, 0,0,0,0);

    repeat (2) tick();
    checkOutput("reset.state", state, 0);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.cap_arm", cap_arm, 0);
    checkOutput("reset.cap_abort", cap_abort, 0);
    checkOutput("reset.cap_count", cap_count, 0);
    reset_n = 1'b1;
    tick();

    // Table: one-shot with buffer_size=2, then stop during ARM.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d.state", i), state, vecs[i].st);
      checkOutput($sformatf("vec%0d.busy", i), busy, vecs[i].busy);
      checkOutput($sformatf("vec%0d.cap_arm", i), cap_arm, vecs[i].arm);
      checkOutput($sformatf("vec%0d.cap_abort", i), cap_abort, vecs[i].abort);
      checkOutput($sformatf("vec%0d.irq", i), irq, vecs[i].irq);
    end
    exp_count = 1;
    checkOutput("table.cap_count", cap_count, exp_count);
    checkOutput("table.trig_pos", trig_pos, 32'h00ABCD);
    checkOutput("table.aborted", aborted, 1);
    checkOutput("table.err_frame", err_frame, 0);

    // Normal one-shot, 128 samples.
    buffer_size = 24'd128;
    base = irq_seen;
    do_start();
    to_drain(19, 24'h000123);
    drain(128, 127, -1, -1);
    checkOutput("oneshot.finish", state, 7);
    checkOutput("oneshot.irq", irq, 1);
    tick();
    checkOutput("oneshot.idle", state, 0);
    checkOutput("oneshot.busy", busy, 0);
    exp_count++;
    checkOutput("oneshot.irq_count", irq_seen - base, 1);
    checkOutput("oneshot.cap_count", cap_count, exp_count);
    checkOutput("oneshot.trig_pos", trig_pos, 32'h000123);
    checkOutput("oneshot.flags", {err_timeout, err_frame, aborted}, 0);

    // Trigger timeout of 50 cycles.
    timeout = 32'd50;
    base = irq_seen;
    do_start();
    cap_ready = 1'b0;
    tick();
    checkOutput("tmo.wait_armed", state, 2);
    n = 0;
    cap_armed = 1'b1;
    while (!cap_abort && n < 200) begin
      tick();
      cap_armed = 1'b0;
      n++;
    end
    checkOutput("tmo.latency", n, 50);
    checkOutput("tmo.state", state, 6);
    checkOutput("tmo.err_timeout", err_timeout, 1);
    checkOutput("tmo.aborted", aborted, 0);
    repeat (3) tick();
    checkOutput("tmo.abort_held", cap_abort, 1);
    checkOutput("tmo.no_irq_yet", irq_seen - base, 0);
    cap_ready = 1'b1;
    tick();
    checkOutput("tmo.exit_idle", state, 0);
    checkOutput("tmo.exit_irq", irq, 1);
    tick();
    checkOutput("tmo.irq_count", irq_seen - base, 1);
    checkOutput("tmo.cap_count", cap_count, exp_count);
    timeout = 32'd0;

    // Continuous mode over three captures, stop during the third readout.
    continuous = 1'b1;
    buffer_size = 24'd4;
    base = irq_seen;
    do_start();
    for (int c = 0; c < 3; c++) begin
      to_drain(3, 24'(c + 7));
      drain(4, 3, -1, (c == 2) ? 1 : -1);
      checkOutput($sformatf("cont%0d.finish", c), state, 7);
      cap_ready = 1'b0;
      tick();
      cap_ready = 1'b1;
      checkOutput($sformatf("cont%0d.next", c), state, (c < 2) ? 1 : 0);
    end
    tick();
    continuous = 1'b0;
    exp_count += 3;
    checkOutput("cont.irq_count", irq_seen - base, 3);
    checkOutput("cont.cap_count", cap_count, exp_count);
    checkOutput("cont.aborted", aborted, 0);
    checkOutput("cont.trig_pos", trig_pos, 9);

    // Stop while waiting for the trigger.
    buffer_size = 24'd128;
    base = irq_seen;
    do_start();
    tick();
    cap_armed = 1'b1;
    tick();
    cap_armed = 1'b0;
    checkOutput("stop.wait_trig", state, 3);
    cap_ready = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("stop.abort", state, 6);
    repeat (4) tick();
    checkOutput("stop.abort_held", cap_abort, 1);
    cap_ready = 1'b1;
    tick();
    checkOutput("stop.idle", state, 0);
    checkOutput("stop.abort_low", cap_abort, 0);
    tick();
    checkOutput("stop.aborted", aborted, 1);
    checkOutput("stop.irq_count", irq_seen - base, 1);
    checkOutput("stop.cap_count", cap_count, exp_count);

    // Framing error: early dma_last on beat 63, still finishes after 128 beats.
    do_start();
    to_drain(2, 24'h000040);
    drain(128, 63, 127, -1);
    checkOutput("frame.finish", state, 7);
    checkOutput("frame.err_frame", err_frame, 1);
    tick();
    exp_count++;
    checkOutput("frame.cap_count", cap_count, exp_count);
    do_start();
    checkOutput("frame.cleared", err_frame, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    checkOutput("frame.stop_pend_abort", state, 6);
    tick();
    checkOutput("frame.idle", state, 0);

    // Reset in the middle of a readout.
    do_start();
    to_drain(2, 24'h000055);
    dma_valid = 1'b1;
    repeat (10) tick();
    dma_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("rst.state", state, 0);
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.cap_count", cap_count, 0);
    checkOutput("rst.trig_pos", trig_pos, 0);
    checkOutput("rst.outs", {cap_arm, cap_abort, irq, err_timeout, err_frame, aborted}, 0);
    tick();
    reset_n = 1'b1;
    tick();
    cap_ready = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("ign%0d.busy", i), busy, 0);
      checkOutput($sformatf("ign%0d.state", i), state, 0);
    end
    start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_seq.md
# capture_seq

Sequencer for the `capture` block and its sample FIFO. Software or a test harness issues `start`/`stop`; the sequencer drives `arm`/`abort`, tracks the capture handshakes, and enforces a trigger timeout. It counts readout beats on the FIFO master side and reports completion, errors and the latched trigger position. The block sits between the register file and the `capture` plus `axisfifo` pair, in the system clock domain.

## Interface
- `saddr_w`, 24, width of sample addresses and counts
- `timeout_w`, 32, width of the trigger-timeout counter
- `clk`  in  1  system clock, the same clock as the FIFO `master_clk`
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle request to begin a capture
- `stop`  in  1  single-cycle request to abort, or to end continuous mode
- `continuous`  in  1  when 1, re-arm automatically after each completed readout
- `timeout`  in  timeout_w  number of cycles to wait for a trigger; 0 disables the timeout
- `buffer_size`  in  saddr_w  number of samples per capture; must be ≥1
- `cap_arm`  out  1  arm pulse to `capture`
- `cap_abort`  out  1  abort level to `capture`
- `cap_ready`, `cap_armed`, `cap_triggered`, `cap_done`  in  1 each  status from `capture`
- `cap_trigger_pos`  in  saddr_w  trigger position from `capture`
- `dma_valid`, `dma_ready`, `dma_last`  in  1 each  FIFO master handshake, observed only
- `busy`  out  1  high in every state except IDLE
- `irq`  out  1  one-cycle pulse when a sequence ends (completion or abort)
- `trig_pos`  out  saddr_w  trigger position latched for the last capture
- `cap_count`  out  16  number of completed captures; wraps at 0xFFFF
- `err_timeout`, `err_frame`, `aborted`  out  1 each  sticky flags, cleared on an accepted `start`
- `state`  out  3  current state encoding, for debug

## Operation
- State encodings: IDLE=0, ARM=1, WAIT_ARMED=2, WAIT_TRIG=3, WAIT_DONE=4, DRAIN=5, ABORT=6, FINISH=7.
- IDLE:
  - `start` && `cap_ready` → ARM. This also clears the sticky flags, clears the timeout and beat counters, and clears `stop_pend`.
  - `start` while `!cap_ready` is ignored.
- ARM: `cap_arm`=1 for exactly this one cycle, then → WAIT_ARMED.
- WAIT_ARMED: `cap_armed` → WAIT_TRIG.
- WAIT_TRIG:
  - `cap_triggered` → WAIT_DONE, and `trig_pos` ← `cap_trigger_pos` on the same edge.
  - If `timeout`≠0, the timeout counter increments each cycle in WAIT_ARMED and WAIT_TRIG. When it reaches `timeout` → ABORT with `err_timeout`=1.
- WAIT_DONE: `cap_done` → DRAIN.
- DRAIN:
  - A beat is `dma_valid && dma_ready`. The beat counter starts at 0.
  - The beat at which counter == `buffer_size`-1 → FINISH.
  - `dma_last` on any other beat sets `err_frame`; the count continues.
  - `dma_last` absent on the final beat also sets `err_frame`.
- FINISH (one cycle):
  - `irq`=1 and `cap_count`+1.
  - `continuous` && `!stop_pend` → ARM (no `cap_ready` check); otherwise → IDLE.
- `stop` in any state from WAIT_ARMED through WAIT_DONE → ABORT, with `aborted`=1.
- `stop` in ARM, DRAIN or FINISH sets `stop_pend`:
  - ARM then proceeds to WAIT_ARMED and aborts there on the next cycle.
  - DRAIN completes its readout and FINISH returns to IDLE.
- ABORT:
  - `cap_abort`=1 held while in ABORT.
  - Leave when `cap_ready`=1 → IDLE, pulsing `irq` on that exit cycle.
- Priority within one cycle: stop > timeout > `cap_triggered`/`cap_done`. `start` is ignored outside IDLE.
- The timeout counter saturates and never wraps. The beat counter is saddr_w bits wide.

## Timing
- All outputs are registered. While `reset_n`=0 every output is 0 and `state`=IDLE; deassertion is synchronous to `clk`.
- `start` accepted at edge N → `cap_arm` high during cycle N+1 → `busy` high from N+1.
- Status inputs are sampled on the edge and act one cycle later.
- Timeout: with `timeout`=T and no trigger, ABORT is entered T cycles after entering WAIT_ARMED.
- Final readout beat at edge N → FINISH in cycle N+1 (`irq`) → IDLE or ARM in cycle N+2.
- Asserting `reset_n` low mid-sequence drops `cap_arm`/`cap_abort` immediately and clears all counters and flags.

## Test plan
- Normal one-shot: `buffer_size`=128, trigger 20 cycles after armed, FIFO delivers 128 beats with `dma_last` on beat 127 → one `irq`, `cap_count`=1, `trig_pos` matches `cap_trigger_pos`, no flags, state back to IDLE.
- Timeout: `timeout`=50, no trigger → `cap_abort` asserted exactly 50 cycles after WAIT_ARMED entry; `err_timeout`=1; `irq` fires when `cap_ready` returns.
- Continuous mode: `continuous`=1 over 3 captures → 3 `irq` pulses, `cap_count`=3. `stop` during the third DRAIN → that readout completes, then IDLE with `aborted`=0.
- Stop in WAIT_TRIG → `cap_abort` stays high until `cap_ready`; then `aborted`=1, one `irq`, and no `cap_count` increment.
- Framing: `dma_last` on beat 63 of 128 → `err_frame`=1 and FINISH still occurs after beat 127. A subsequent `start` clears `err_frame`.
- Reset mid-DRAIN with `reset_n` low for 1 cycle → all outputs 0 immediately. `start` while `cap_ready`=0 → ignored, and `busy` stays 0.
